// File: rtl/multicycle_control_fsm_if.sv
// Control bundle between the multicycle sequencer and the datapath.
// master: the sequencer (samples run/opcode/zero/mem_ready, drives strobes and status).
// slave : the datapath / environment side.
//   run, opcode, zero, mem_ready        -> sequencer
//   pc_write, pc_src, ir_write,
//   reg_write, RegDst, ALUSrc, aluop,
//   mem_req, mem_write, mem_to_reg      <- datapath strobes and mux selects
//   retired, halted, illegal,
//   instr_count, state                  <- status / debug
interface multicycle_control_fsm_if #(
  parameter int unsigned CNT_W = 16
);
  logic             run;
  logic [3:0]       opcode;
  logic             zero;
  logic             mem_ready;
  logic             pc_write;
  logic [1:0]       pc_src;
  logic             ir_write;
  logic             reg_write;
  logic             RegDst;
  logic             ALUSrc;
  logic [2:0]       aluop;
  logic             mem_req;
  logic             mem_write;
  logic             mem_to_reg;
  logic             retired;
  logic             halted;
  logic             illegal;
  logic [CNT_W-1:0] instr_count;
  logic [2:0]       state;

  modport master (
    input  run, opcode, zero, mem_ready,
    output pc_write, pc_src, ir_write, reg_write, RegDst, ALUSrc, aluop,
    output mem_req, mem_write, mem_to_reg, retired, halted, illegal, instr_count, state
  );

  modport slave (
    output run, opcode, zero, mem_ready,
    input  pc_write, pc_src, ir_write, reg_write, RegDst, ALUSrc, aluop,
    input  mem_req, mem_write, mem_to_reg, retired, halted, illegal, instr_count, state
  );
endinterface

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle control sequencer for the 16-bit single-issue CPU datapath.
// Steps each instruction through FETCH/DECODE/EXEC/MEM/WB, drives datapath strobes,
// handshakes data-memory accesses with mem_req/mem_ready and counts retired instructions.
// Ports:
//   clk  - system clock, rising edge
//   rst  - asynchronous active-low reset
//   bus  - control bundle (master side), see multicycle_control_fsm_if
module multicycle_control_fsm #(
  parameter int unsigned CNT_W = 16
) (
  input logic                       clk,
  input logic                       rst,
  multicycle_control_fsm_if.master  bus
);

  typedef enum logic [2:0] {
    StFetch  = 3'd0,
    StDecode = 3'd1,
    StExec   = 3'd2,
    StMem    = 3'd3,
    StWb     = 3'd4,
    StHalt   = 3'd5
  } state_e;

  localparam logic [3:0] OpSlt  = 4'h4;
  localparam logic [3:0] OpAddi = 4'h5;
  localparam logic [3:0] OpLw   = 4'h6;
  localparam logic [3:0] OpSw   = 4'h7;
  localparam logic [3:0] OpBeq  = 4'h8;
  localparam logic [3:0] OpBne  = 4'h9;
  localparam logic [3:0] OpJmp  = 4'hA;
  localparam logic [3:0] OpHalt = 4'hF;

  state_e           state_q, state_d;
  logic [3:0]       op_q;
  logic             illegal_q;
  logic             halt_ack_q;  // HALT retire pulse already issued
  logic [CNT_W-1:0] cnt_q;

  logic       pc_write, ir_write, reg_write, reg_dst, alu_src;
  logic       mem_req, mem_write, mem_to_reg, retired, halted, set_illegal;
  logic [1:0] pc_src;
  logic [2:0] aluop;
  logic       op_rtype, op_illegal_in;

  assign op_rtype      = (op_q <= OpSlt);
  assign op_illegal_in = (bus.opcode inside {[4'hB:4'hE]});

  always_comb begin
    state_d     = state_q;
    pc_write    = 1'b0;
    pc_src      = 2'b00;
    ir_write    = 1'b0;
    reg_write   = 1'b0;
    reg_dst     = 1'b0;
    alu_src     = 1'b0;
    aluop       = 3'b000;
    mem_req     = 1'b0;
    mem_write   = 1'b0;
    mem_to_reg  = 1'b0;
    retired     = 1'b0;
    halted      = 1'b0;
    set_illegal = 1'b0;

    // ALU controls stay stable from EXEC through MEM and WB.
    if (state_q inside {StExec, StMem, StWb}) begin
      if (op_rtype) begin
        aluop = op_q[2:0];
      end else if (op_q == OpBeq || op_q == OpBne) begin
        aluop = 3'b001;
      end
      alu_src = (op_q == OpAddi) || (op_q == OpLw) || (op_q == OpSw);
    end

    case (state_q)
      StFetch: begin
        // Gated by rst so every strobe reads 0 while reset is held.
        if (bus.run && rst) begin
          pc_write = 1'b1;
          ir_write = 1'b1;
          state_d  = StDecode;
        end
      end
      StDecode: begin
        // Live opcode: op_q is only loaded at the end of this cycle.
        if (op_illegal_in) begin
          set_illegal = 1'b1;
          retired     = 1'b1;
          state_d     = StFetch;
        end else if (bus.opcode == OpHalt) begin
          state_d = StHalt;
        end else begin
          state_d = StExec;
        end
      end
      StExec: begin
        state_d = StFetch;
        if (op_rtype || op_q == OpAddi) begin
          state_d = StWb;
        end else if (op_q == OpLw || op_q == OpSw) begin
          state_d = StMem;
        end else if (op_q == OpBeq || op_q == OpBne) begin
          pc_src   = 2'b01;
          pc_write = (op_q == OpBeq) ? bus.zero : !bus.zero;
          retired  = 1'b1;
        end else if (op_q == OpJmp) begin
          pc_src   = 2'b10;
          pc_write = 1'b1;
          retired  = 1'b1;
        end
      end
      StMem: begin
        mem_req   = 1'b1;
        mem_write = (op_q == OpSw);
        if (bus.mem_ready) begin
          if (op_q == OpSw) begin
            retired = 1'b1;
            state_d = StFetch;
          end else begin
            state_d = StWb;
          end
        end
      end
      StWb: begin
        reg_write  = 1'b1;
        reg_dst    = op_rtype;
        mem_to_reg = (op_q == OpLw);
        retired    = 1'b1;
        state_d    = StFetch;
      end
      StHalt: begin
        halted  = 1'b1;
        retired = !halt_ack_q;
      end
      default: begin
        // Unreachable codes 6/7: recover quietly.
        aluop   = 3'b000;
        alu_src = 1'b0;
        state_d = StFetch;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StFetch;
      op_q       <= 4'h0;
      illegal_q  <= 1'b0;
      halt_ack_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == StDecode) begin
        op_q <= bus.opcode;
      end
      if (set_illegal) begin
        illegal_q <= 1'b1;
      end
      if (state_q == StHalt) begin
        halt_ack_q <= 1'b1;
      end
      if (retired) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign bus.pc_write    = pc_write;
  assign bus.pc_src      = pc_src;
  assign bus.ir_write    = ir_write;
  assign bus.reg_write   = reg_write;
  assign bus.RegDst      = reg_dst;
  assign bus.ALUSrc      = alu_src;
  assign bus.aluop       = aluop;
  assign bus.mem_req     = mem_req;
  assign bus.mem_write   = mem_write;
  assign bus.mem_to_reg  = mem_to_reg;
  assign bus.retired     = retired;
  assign bus.halted      = halted;
  assign bus.illegal     = illegal_q;
  assign bus.instr_count = cnt_q;
  assign bus.state       = state_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
module tb_multicycle_control_fsm;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst2 = 1'b0;

  always #5 clk = ~clk;

  multicycle_control_fsm_if #(.CNT_W(16)) bus ();
  multicycle_control_fsm_if #(.CNT_W(4))  bus2 ();

  multicycle_control_fsm #(.CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Narrow counter instance so the wrap can be reached by free running.
  multicycle_control_fsm #(.CNT_W(4)) dut2 (
    .clk (clk),
    .rst (rst2),
    .bus (bus2)
  );

  typedef struct {
    logic [3:0] op;
    logic       z;
    int         nwait;
    int         lat;
    int         nreg;
    int         nmem;
    int         nmemw;
    int         npcw;
    int         regdst;
    int         m2r;
  } vec_t;

  int    n_cmp = 0;
  int    n_fail = 0;
  int    exp_count = 0;
  int    exp_illegal = 0;
  string ctx = "";

  int obs_lat, obs_reg, obs_mem, obs_memw, obs_pcw, obs_regdst, obs_m2r, obs_aluop, obs_alusrc;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s %s: got %0d, expected %0d", ctx, name, act, exp);
    end
  endtask

  function automatic int out_bits();
    return int'({bus.pc_write, bus.pc_src, bus.ir_write, bus.reg_write, bus.RegDst, bus.ALUSrc,
                 bus.aluop, bus.mem_req, bus.mem_write, bus.mem_to_reg, bus.retired,
                 bus.halted, bus.illegal, bus.state});
  endfunction

  // Reference: what each instruction class must do, by counts and latency.
  function automatic vec_t model(input logic [3:0] op, input logic z, input int n);
    vec_t v;
    v.op = op; v.z = z; v.nwait = n;
    v.nreg = 0; v.nmem = 0; v.nmemw = 0; v.npcw = 1; v.regdst = 0; v.m2r = 0;
    if (op <= 4'h4) begin
      v.lat = 4; v.nreg = 1; v.regdst = 1;
    end else if (op == 4'h5) begin
      v.lat = 4; v.nreg = 1;
    end else if (op == 4'h6) begin
      v.lat = 5 + n; v.nreg = 1; v.nmem = n + 1; v.m2r = 1;
    end else if (op == 4'h7) begin
      v.lat = 4 + n; v.nmem = n + 1; v.nmemw = n + 1;
    end else if (op == 4'h8) begin
      v.lat = 3; v.npcw = 1 + int'(z);
    end else if (op == 4'h9) begin
      v.lat = 3; v.npcw = 1 + int'(!z);
    end else if (op == 4'hA) begin
      v.lat = 3; v.npcw = 2;
    end else if (op == 4'hF) begin
      v.lat = 3;
    end else begin
      v.lat = 2;
    end
    return v;
  endfunction

  task automatic run_instr(input logic [3:0] op, input logic z, input int nwait);
    int mseen;
    bit done;
    mseen = 0; done = 0;
    obs_lat = 0; obs_reg = 0; obs_mem = 0; obs_memw = 0; obs_pcw = 0;
    obs_regdst = 0; obs_m2r = 0; obs_aluop = 0; obs_alusrc = 0;
    for (int c = 1; c <= 40 && !done; c++) begin
      @(negedge clk);
      bus.run       = (c == 1);
      bus.opcode    = (c <= 2) ? op : 4'($urandom);
      bus.zero      = z;
      bus.mem_ready = (mseen >= nwait);
      #1;
      if (c == 1) begin
        check("start_state", int'(bus.state), 0);
        check("instr_count", int'(bus.instr_count), exp_count);
        check("illegal_sticky", int'(bus.illegal), exp_illegal);
      end
      if (bus.reg_write) begin
        obs_reg++;
        obs_regdst = int'(bus.RegDst);
        obs_m2r    = int'(bus.mem_to_reg);
      end
      if (bus.mem_req) begin
        obs_mem++;
        if (bus.mem_write) obs_memw++;
        mseen++;
      end
      if (bus.pc_write) obs_pcw++;
      if (bus.retired) begin
        done       = 1;
        obs_lat    = c;
        obs_aluop  = int'(bus.aluop);
        obs_alusrc = int'(bus.ALUSrc);
      end
    end
  endtask

  task automatic apply(input vec_t v);
    ctx = $sformatf("op=%h z=%0d n=%0d", v.op, v.z, v.nwait);
    run_instr(v.op, v.z, v.nwait);
    check("latency", obs_lat, v.lat);
    check("reg_write_cycles", obs_reg, v.nreg);
    check("mem_req_cycles", obs_mem, v.nmem);
    check("mem_write_cycles", obs_memw, v.nmemw);
    check("pc_write_cycles", obs_pcw, v.npcw);
    check("RegDst", obs_regdst, v.regdst);
    check("mem_to_reg", obs_m2r, v.m2r);
    if (v.op <= 4'h9) begin
      check("aluop", obs_aluop,
            (v.op <= 4'h4) ? int'(v.op) % 8 : ((v.op >= 4'h8) ? 1 : 0));
      check("ALUSrc", obs_alusrc, (v.op >= 4'h5 && v.op <= 4'h7) ? 1 : 0);
    end
    exp_count++;
    if (v.op >= 4'hB && v.op <= 4'hE) exp_illegal = 1;
  endtask

  vec_t tbl[12];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int ret;
    bit seen;

    tbl[0]  = '{4'h0, 1'b0, 0, 4, 1, 0, 0, 1, 1, 0};
    tbl[1]  = '{4'h6, 1'b0, 3, 8, 1, 4, 0, 1, 0, 1};
    tbl[2]  = '{4'h8, 1'b1, 0, 3, 0, 0, 0, 2, 0, 0};
    tbl[3]  = '{4'h9, 1'b1, 0, 3, 0, 0, 0, 1, 0, 0};
    tbl[4]  = '{4'hC, 1'b0, 0, 2, 0, 0, 0, 1, 0, 0};
    tbl[5]  = '{4'h1, 1'b0, 0, 4, 1, 0, 0, 1, 1, 0};
    tbl[6]  = '{4'h7, 1'b0, 2, 6, 0, 3, 3, 1, 0, 0};
    tbl[7]  = '{4'h5, 1'b1, 0, 4, 1, 0, 0, 1, 0, 0};
    tbl[8]  = '{4'hA, 1'b0, 0, 3, 0, 0, 0, 2, 0, 0};
    tbl[9]  = '{4'h9, 1'b0, 0, 3, 0, 0, 0, 2, 0, 0};
    tbl[10] = '{4'h8, 1'b0, 0, 3, 0, 0, 0, 1, 0, 0};
    tbl[11] = '{4'h6, 1'b0, 0, 5, 1, 1, 0, 1, 0, 1};

    bus.run = 1'b1; bus.opcode = 4'h0; bus.zero = 1'b0; bus.mem_ready = 1'b0;
    bus2.run = 1'b1; bus2.opcode = 4'hC; bus2.zero = 1'b0; bus2.mem_ready = 1'b0;

    // Reset with run held high: every output must read 0.
    #2 rst = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    ctx = "reset";
    check("outputs", out_bits(), 0);
    check("instr_count", int'(bus.instr_count), 0);
    @(negedge clk);
    bus.run = 1'b0;
    rst = 1'b1;

    foreach (tbl[i]) apply(tbl[i]);

    for (int i = 0; i < 150; i++) begin
      apply(model(4'($urandom_range(0, 14)), 1'($urandom), int'($urandom_range(0, 4))));
    end

    // HALT retires once then freezes even with run held.
    apply(model(4'hF, 1'b0, 0));
    ctx = "halted";
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.run = 1'b1;
      bus.opcode = 4'($urandom);
      #1;
      check("halted", int'(bus.halted), 1);
      check("state", int'(bus.state), 5);
      check("retired", int'(bus.retired), 0);
      check("pc_write", int'(bus.pc_write), 0);
      check("instr_count", int'(bus.instr_count), exp_count);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    ctx = "reset_from_halt";
    check("outputs", out_bits(), 0);
    check("instr_count", int'(bus.instr_count), 0);
    @(negedge clk);
    bus.run = 1'b0;
    rst = 1'b1;
    exp_count = 0;
    exp_illegal = 0;

    apply(model(4'h2, 1'b0, 0));

    // Asynchronous reset in the middle of a stalled SW access.
    ctx = "sw_mid_mem";
    seen = 0;
    for (int c = 1; c <= 10 && !seen; c++) begin
      @(negedge clk);
      bus.run = (c == 1);
      bus.opcode = 4'h7;
      bus.mem_ready = 1'b0;
      #1;
      if (bus.state == 3'd3) seen = 1;
    end
    check("reached_mem", int'(seen), 1);
    check("mem_req", int'(bus.mem_req), 1);
    check("mem_write", int'(bus.mem_write), 1);
    bus.run = 1'b1;
    #1 rst = 1'b0;
    #1;
    check("outputs", out_bits(), 0);
    check("instr_count", int'(bus.instr_count), 0);
    @(negedge clk);
    bus.run = 1'b0;
    rst = 1'b1;
    exp_count = 0;
    apply(model(4'h3, 1'b0, 0));
    apply(model(4'h7, 1'b1, 1));

    // Counter wrap on the narrow instance fed a stream of illegal opcodes.
    ctx = "wrap";
    @(negedge clk);
    rst2 = 1'b1;
    ret = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      #1;
      check("instr_count", int'(bus2.instr_count), ret % 16);
      if (bus2.retired) ret++;
    end
    check("retires_past_wrap", int'(ret > 16), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
